// File: rtl/affine_pkg.sv
// Shared types and constants for the affine batch sequencer.
package affine_pkg;

    localparam int unsigned DEF_FRAC = 8;
    localparam int unsigned PT_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL0,
        MUL1,
        MUL2,
        MUL3,
        SUM,
        OUT
    } state_t;

    typedef struct packed {
        logic [PT_W-1:0] x;
        logic [PT_W-1:0] y;
    } pt_t;

endpackage

// File: rtl/affine_pt_fifo.sv
// Point FIFO: wrap-bit pointers, full/empty decode, synchronous flush.
module affine_pt_fifo
    import affine_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_push,
    input  pt_t  i_data,
    input  logic i_pop,
    output pt_t  o_data_c,
    output logic o_full_c,
    output logic o_empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    pt_t         r_mem [DEPTH];
    logic        w_push_ok;
    logic        w_pop_ok;

    assign o_full_c  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_empty_c = (r_wr == r_rd);
    assign o_data_c  = r_mem[r_rd[AW-1:0]];

    // A push while full is refused even when a pop frees a slot this cycle.
    assign w_push_ok = i_push & ~o_full_c & ~i_flush;
    assign w_pop_ok  = i_pop & ~o_empty_c & ~i_flush;

    // Pointer update; flush empties the FIFO and drops any same-cycle push.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop_ok)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/mul.sv
// Signed WIDTH x WIDTH multiplier, full-width combinational product.
module mul #(
    parameter int unsigned WIDTH = 16
) (
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    output logic signed [2*WIDTH-1:0] o_prod_c
);

    assign o_prod_c = i_a * i_b;

endmodule

// File: rtl/affine_batch_sched.sv
// Batch sequencer: one shared multiplier, four products per point, streamed results.
module affine_batch_sched
    import affine_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned FRAC  = DEF_FRAC,
    parameter int unsigned SAT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_a,
    input  logic [15:0] cfg_b,
    input  logic [15:0] cfg_d,
    input  logic [15:0] cfg_e,
    input  logic [15:0] cfg_tx,
    input  logic [15:0] cfg_ty,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  batch_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_x,
    output logic [15:0] out_y,
    output logic        busy,
    output logic        done,
    output logic        irq,
    input  logic        irq_clr,
    output logic [7:0]  processed
);

    localparam int unsigned PROD_W = 2 * PT_W;
    localparam int unsigned SUM_W  = PROD_W + 2;
    localparam logic signed [SUM_W-1:0] C_MAX = SUM_W'(32'sd32767);
    localparam logic signed [SUM_W-1:0] C_MIN = SUM_W'(-32'sd32768);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [PT_W-1:0]   r_x, r_y;
    logic signed [PT_W-1:0]   r_a, r_b, r_d, r_e, r_tx, r_ty;
    logic signed [PROD_W-1:0] r_p0, r_p1, r_p2, r_p3;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PT_W-1:0]   w_op_a, w_op_b;
    logic signed [SUM_W-1:0]  w_sum_x, w_sum_y;
    logic [PT_W-1:0]          r_out_x, r_out_y;
    logic                     r_out_valid, r_busy, r_done, r_irq;
    logic [7:0]               r_len, r_processed;
    logic                     w_full, w_empty, w_pop, w_hs;
    logic                     w_start_ok, w_last, w_done_evt;
    pt_t                      w_head;
    pt_t                      w_in_pt;

    assign w_in_pt    = {in_x, in_y};
    assign in_ready   = ~w_full;
    assign out_valid  = r_out_valid;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;
    assign busy       = r_busy;
    assign done       = r_done;
    assign irq        = r_irq;
    assign processed  = r_processed;

    assign w_start_ok = start & ~r_busy & ~abort;
    assign w_last     = (8'(r_processed + 8'd1) == r_len);
    assign w_done_evt = (w_start_ok & (batch_len == 8'd0)) | (w_hs & w_last);

    affine_pt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (abort),
        .i_push    (in_valid),
        .i_data    (w_in_pt),
        .i_pop     (w_pop),
        .o_data_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    mul #(.WIDTH(PT_W)) u_mul (
        .i_a      (w_op_a),
        .i_b      (w_op_b),
        .o_prod_c (w_prod)
    );

    // Each product is shifted on its own; the sum is carried wide so the
    // clamp sees the true sign, and its low 16 bits equal an 18-bit wrap.
    assign w_sum_x = SUM_W'(r_p0 >>> FRAC) + SUM_W'(r_p1 >>> FRAC) + SUM_W'(r_tx);
    assign w_sum_y = SUM_W'(r_p2 >>> FRAC) + SUM_W'(r_p3 >>> FRAC) + SUM_W'(r_ty);

    function automatic logic [PT_W-1:0] fit16(input logic signed [SUM_W-1:0] v);
        logic [PT_W-1:0] res;
        res = v[PT_W-1:0];
        if (SAT != 0) begin
            if (v > C_MAX)      res = 16'h7FFF;
            else if (v < C_MIN) res = 16'h8000;
        end
        return res;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, FIFO pop, multiplier operand mux and output handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_op_a      = '0;
        w_op_b      = '0;
        w_hs        = 1'b0;
        case (r_state)
            // Nothing is in flight while idle, so only processed counts.
            IDLE: if (r_busy && !w_empty && (r_processed < r_len)) w_state_nxt = LOAD;
            LOAD: begin w_pop = 1'b1; w_state_nxt = MUL0; end
            MUL0: begin w_op_a = r_a; w_op_b = r_x; w_state_nxt = MUL1; end
            MUL1: begin w_op_a = r_b; w_op_b = r_y; w_state_nxt = MUL2; end
            MUL2: begin w_op_a = r_d; w_op_b = r_x; w_state_nxt = MUL3; end
            MUL3: begin w_op_a = r_e; w_op_b = r_y; w_state_nxt = SUM;  end
            SUM:  w_state_nxt = OUT;
            OUT:  if (out_ready) begin w_hs = 1'b1; w_state_nxt = IDLE; end
            default: w_state_nxt = IDLE;
        endcase
        if (abort) begin
            w_state_nxt = IDLE;
            w_pop       = 1'b0;
            w_hs        = 1'b0;
        end
    end

    // Datapath, batch bookkeeping and completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0; r_y <= '0;
            r_a <= '0; r_b <= '0; r_d <= '0; r_e <= '0; r_tx <= '0; r_ty <= '0;
            r_p0 <= '0; r_p1 <= '0; r_p2 <= '0; r_p3 <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_irq       <= 1'b0;
            r_len       <= '0;
            r_processed <= '0;
        end else begin
            r_done <= w_done_evt;
            // A completion in this or the previous cycle overrides a clear.
            r_irq  <= w_done_evt | r_done | (r_irq & ~irq_clr);
            if (r_state == LOAD) begin
                r_x  <= w_head.x;
                r_y  <= w_head.y;
                r_a  <= cfg_a;
                r_b  <= cfg_b;
                r_d  <= cfg_d;
                r_e  <= cfg_e;
                r_tx <= cfg_tx;
                r_ty <= cfg_ty;
            end
            if (r_state == MUL0) r_p0 <= w_prod;
            if (r_state == MUL1) r_p1 <= w_prod;
            if (r_state == MUL2) r_p2 <= w_prod;
            if (r_state == MUL3) r_p3 <= w_prod;
            if (abort) begin
                r_busy      <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                if (r_state == SUM) begin
                    r_out_x     <= fit16(w_sum_x);
                    r_out_y     <= fit16(w_sum_y);
                    r_out_valid <= 1'b1;
                end
                if (w_start_ok) begin
                    r_len       <= batch_len;
                    r_processed <= '0;
                    r_busy      <= (batch_len != 8'd0);
                end
                if (w_hs) begin
                    r_out_valid <= 1'b0;
                    r_processed <= r_processed + 8'd1;
                    if (w_last) r_busy <= 1'b0;
                end
            end
        end
    end

endmodule
